// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor rounding,
// used by both the TX sender and the RX block.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return (clk_freq + (baud / 32'd2)) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count; a write into a full queue
// is accepted only when a read frees a slot in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_s;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full_s    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign do_rd_s   = rd_en_i & ~empty_o;
    assign do_wr_s   = wr_en_i & (~full_s | do_rd_s);
    assign drop_o    = wr_en_i & full_s & ~do_rd_s;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_sender.sv
// Button-to-UART sender: each rising edge of send queues data_in, and queued
// bytes are serialised back-to-back on tx as 8N1.
module uart_tx_sender
    import uart_pkg::*;
#(
    parameter  int unsigned CLK_FREQ   = 100_000_000,
    parameter  int unsigned BAUD       = 9600,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int          CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          send,
    input  logic [7:0]    data_in,
    output logic          tx,
    output logic          busy,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    localparam int unsigned     CPB       = clks_per_bit(CLK_FREQ, BAUD);
    localparam int              BW        = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CPB - 1);
    localparam logic [BW-1:0]   BAUD_ZERO = {BW{1'b0}};

    uart_state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q;
    logic          overflow_q;
    logic          send_dly_q;
    logic          push_s;
    logic          pop_s;
    logic          bit_end_s;
    logic          fifo_empty_s;
    logic          fifo_drop_s;
    logic [7:0]    fifo_data_s;

    assign push_s    = send & ~send_dly_q;
    assign bit_end_s = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push_s),
        .wr_data_i (data_in),
        .rd_en_i   (pop_s),
        .rd_data_o (fifo_data_s),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty_s),
        .drop_o    (fifo_drop_s)
    );

    // Frame sequencing; STOP chains straight into START when more bytes wait.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1'b1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = BAUD_ZERO;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_data_s;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    baud_d  = BAUD_ZERO;
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_d  = BAUD_ZERO;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    baud_d = BAUD_ZERO;
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_data_s;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                baud_d  = BAUD_ZERO;
                bit_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Line level follows the current state, one cycle behind it.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= BAUD_ZERO;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            send_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= (state_q != IDLE) | ~fifo_empty_s;
            overflow_q <= fifo_drop_s;
            send_dly_q <= send;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_sender.sv
// Directed bench for uart_tx_sender at CLKS_PER_BIT=10: tx waveforms are
// logged on the falling edge and compared against hand-built frame streams.
module tb_uart_tx_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    logic capture = 1'b0;
    logic tx_log[$];
    logic busy_log[$];
    logic exp_q[$];
    int   ovf_cnt;
    int   fifo_max;

    uart_tx_sender #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .send       (send),
        .data_in    (data_in),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Falling-edge recorder for the windowed tests.
    always @(negedge clk) begin
        if (capture) begin
            tx_log.push_back(tx);
            busy_log.push_back(busy);
            if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
            if (int'(fifo_count) > fifo_max) fifo_max <= int'(fifo_count);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_idle(input int n);
        repeat (n) exp_q.push_back(1'b1);
    endtask

    task automatic add_frame(input logic [7:0] b);
        repeat (10) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) exp_q.push_back(b[i]);
        end
        repeat (10) exp_q.push_back(1'b1);
    endtask

    // Called just after a rising edge; the next rising edge is the push edge E,
    // so log index 0 is the falling edge before E and the start bit is at index 3.
    task automatic begin_capture();
        tx_log.delete();
        busy_log.delete();
        exp_q.delete();
        ovf_cnt  = 0;
        fifo_max = 0;
        capture  = 1'b1;
        add_idle(3);
    endtask

    task automatic end_capture(input string tag);
        logic e;
        capture = 1'b0;
        check({tag, " log length"}, 32'(tx_log.size() >= exp_q.size()), 32'd1);
        for (int i = 0; i < tx_log.size(); i++) begin
            e = (i < exp_q.size()) ? exp_q[i] : 1'b1;
            check($sformatf("%s tx@%0d", tag, i), 32'(tx_log[i]), 32'(e));
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        send    = 1'b1;
        data_in = b;
        @(posedge clk);
        #1 send = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        send    = 1'b0;
        data_in = 8'h00;
        #12;
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset fifo_count", 32'(fifo_count), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle line after reset.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle tx", 32'(tx), 32'd1);
            check("idle busy", 32'(busy), 32'd0);
            check("idle fifo_count", 32'(fifo_count), 32'd0);
        end
        @(posedge clk);
        #1;

        // Single byte A5: start bit at E+2, busy low again at E+102.
        begin_capture();
        add_frame(8'hA5);
        pulse(8'hA5);
        gap(110);
        end_capture("single");
        check("single busy@E", 32'(busy_log[1]), 32'd0);
        check("single busy@E+1", 32'(busy_log[2]), 32'd1);
        check("single busy@E+101", 32'(busy_log[102]), 32'd1);
        check("single busy@E+102", 32'(busy_log[103]), 32'd0);
        check("single fifo_max", 32'(fifo_max), 32'd1);
        check("single overflow", 32'(ovf_cnt), 32'd0);

        // Level held high gives exactly one frame.
        begin_capture();
        add_frame(8'h3C);
        send    = 1'b1;
        data_in = 8'h3C;
        gap(300);
        send = 1'b0;
        gap(10);
        end_capture("held");
        check("held fifo_max", 32'(fifo_max), 32'd1);
        check("held overflow", 32'(ovf_cnt), 32'd0);
        check("held busy end", 32'(busy_log[busy_log.size()-1]), 32'd0);

        // Five pulses three cycles apart run back-to-back.
        begin_capture();
        for (int k = 1; k <= 5; k++) begin
            add_frame(8'(k));
            pulse(8'(k));
            if (k < 5) gap(1);
        end
        gap(520);
        end_capture("five");
        check("five overflow", 32'(ovf_cnt), 32'd0);
        check("five fifo_max", 32'(fifo_max), 32'd4);
        check("five busy last", 32'(busy_log[502]), 32'd1);
        check("five busy drop", 32'(busy_log[503]), 32'd0);

        // Six pushes during one frame: four queue, two are dropped.
        begin_capture();
        add_frame(8'h10);
        pulse(8'h10);
        gap(5);
        for (int k = 0; k < 6; k++) begin
            pulse(8'h11 + 8'(k));
            gap(1);
        end
        for (int k = 0; k < 4; k++) add_frame(8'h11 + 8'(k));
        gap(520);
        end_capture("six");
        check("six overflow pulses", 32'(ovf_cnt), 32'd2);
        check("six fifo_max", 32'(fifo_max), 32'd4);

        // Reset 35 cycles into a frame (data bit 2 of 5A is low) with 2 queued.
        pulse(8'h5A);
        pulse(8'h66);
        pulse(8'h77);
        gap(32);
        #1;
        check("pre-reset fifo_count", 32'(fifo_count), 32'd2);
        check("pre-reset busy", 32'(busy), 32'd1);
        check("pre-reset tx", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        check("async reset tx", 32'(tx), 32'd1);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset fifo_count", 32'(fifo_count), 32'd0);
        check("async reset overflow", 32'(overflow), 32'd0);
        gap(3);
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            check("post-reset tx", 32'(tx), 32'd1);
            check("post-reset busy", 32'(busy), 32'd0);
            check("post-reset fifo_count", 32'(fifo_count), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
